// File: rtl/sram_burst_ctrl.sv
// Line-burst controller for the DE2 asynchronous 16-bit SRAM: one line request is split
// into consecutive half-word beats, each stretched by WAIT_CYCLES extra clocks.
module sram_burst_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int DQ_W        = 16,
    parameter int WORD_W      = 32,
    parameter int BURST_LEN   = 2,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [31:0]                 req_addr,
    input  logic [BURST_LEN*WORD_W-1:0] wdata,
    output logic [BURST_LEN*WORD_W-1:0] rdata,
    output logic                        done,
    inout  wire  [DQ_W-1:0]             sram_dq,
    output logic [ADDR_W-1:0]           sram_addr,
    output logic                        sram_we_n,
    output logic                        sram_oe_n,
    output logic                        sram_ce_n,
    output logic                        sram_ub_n,
    output logic                        sram_lb_n
);

    localparam int BEATS    = BURST_LEN * WORD_W / DQ_W;
    localparam int LINE_W   = BURST_LEN * WORD_W;
    localparam int BEAT_LOG = $clog2(BEATS);
    localparam int BEAT_W   = (BEATS > 1) ? BEAT_LOG : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [2:0]        LAST_WAIT  = 3'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1'b1) << BEAT_LOG) - ADDR_W'(1'b1));

    if ((WORD_W % DQ_W) != 32'sd0 || BURST_LEN < 32'sd1 ||
        (BURST_LEN & (BURST_LEN - 32'sd1)) != 32'sd0 ||
        WAIT_CYCLES < 32'sd0 || WAIT_CYCLES > 32'sd7) begin : g_bad_params
        $error("sram_burst_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [2:0]          wait_q, wait_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   cap_q, cap_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;

    logic                req_ready_q, req_ready_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic [DQ_W-1:0]     dq_out_q, dq_out_d;

    logic [ADDR_W-1:0]   req_hw_s;
    logic                in_access_s;

    assign req_hw_s = ADDR_W'(req_addr[31:1]);

    // Next-state sequencing: request latch, beat/wait counting and read capture.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        is_wr_d = is_wr_q;
        base_d  = base_q;
        wline_d = wline_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ACCESS;
                    is_wr_d = req_we;
                    base_d  = req_hw_s & ALIGN_MASK;
                    wline_d = wdata;
                    beat_d  = {BEAT_W{1'b0}};
                    wait_d  = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    if (!is_wr_q) begin
                        cap_d[beat_q*DQ_W +: DQ_W] = sram_dq;
                    end else begin
                        cap_d = cap_q;
                    end
                    wait_d = 3'd0;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        // rdata only moves when a whole read line has been gathered
                        if (!is_wr_q) begin
                            rdata_d = cap_d;
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1'b1);
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so they register cleanly.
    always_comb begin
        in_access_s = (state_d == ST_ACCESS);
        req_ready_d = (state_d == ST_IDLE);
        done_d      = (state_d == ST_DONE);
        ce_n_d      = !in_access_s;
        oe_n_d      = !(in_access_s && !is_wr_d);
        // with wait states the first cycle of a write beat is address setup
        we_n_d      = !(in_access_s && is_wr_d && ((LAST_WAIT == 3'd0) || (wait_d != 3'd0)));
        if (in_access_s) begin
            sram_addr_d = base_d + ADDR_W'(beat_d);
        end else begin
            sram_addr_d = sram_addr_q;
        end
        if (in_access_s && is_wr_d) begin
            dq_oe_d  = 1'b1;
            dq_out_d = wline_d[beat_d*DQ_W +: DQ_W];
        end else begin
            dq_oe_d  = 1'b0;
            dq_out_d = {DQ_W{1'b0}};
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= {BEAT_W{1'b0}};
            wait_q      <= 3'd0;
            is_wr_q     <= 1'b0;
            base_q      <= {ADDR_W{1'b0}};
            wline_q     <= {LINE_W{1'b0}};
            cap_q       <= {LINE_W{1'b0}};
            rdata_q     <= {LINE_W{1'b0}};
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            sram_addr_q <= {ADDR_W{1'b0}};
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= {DQ_W{1'b0}};
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            is_wr_q     <= is_wr_d;
            base_q      <= base_d;
            wline_q     <= wline_d;
            cap_q       <= cap_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign sram_addr = sram_addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_ub_n = ce_n_q;
    assign sram_lb_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_dq   = dq_oe_q ? dq_out_q : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl: default instance plus an 8-beat zero-wait instance,
// each attached to a behavioural asynchronous SRAM.
module tb_sram_burst_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // default instance: BEATS = 4, one wait state
    logic        v0, we0i;
    logic [31:0] a0;
    logic [63:0] wd0, rd0;
    logic        rdy0, done0, we0_n, oe0_n, ce0_n, ub0_n, lb0_n;
    logic [17:0] sa0;
    wire  [15:0] dq0;

    // sweep instance: BEATS = 8, no wait states
    logic         v1, we1i;
    logic [31:0]  a1;
    logic [127:0] wd1, rd1;
    logic         rdy1, done1, we1_n, oe1_n, ce1_n, ub1_n, lb1_n;
    logic [17:0]  sa1;
    wire  [15:0]  dq1;

    sram_burst_ctrl u0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we0i),
        .req_addr(a0), .wdata(wd0), .rdata(rd0), .done(done0), .sram_dq(dq0),
        .sram_addr(sa0), .sram_we_n(we0_n), .sram_oe_n(oe0_n), .sram_ce_n(ce0_n),
        .sram_ub_n(ub0_n), .sram_lb_n(lb0_n)
    );

    sram_burst_ctrl #(.BURST_LEN(4), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1i),
        .req_addr(a1), .wdata(wd1), .rdata(rd1), .done(done1), .sram_dq(dq1),
        .sram_addr(sa1), .sram_we_n(we1_n), .sram_oe_n(oe1_n), .sram_ce_n(ce1_n),
        .sram_ub_n(ub1_n), .sram_lb_n(lb1_n)
    );

    // SRAM models; preload port shares the single writer process per array
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    logic        pl_en, pl_sel;
    logic [17:0] pl_addr;
    logic [15:0] pl_data;

    assign dq0 = (!ce0_n && !oe0_n && we0_n) ? mem0[sa0] : 16'bz;
    assign dq1 = (!ce1_n && !oe1_n && we1_n) ? mem1[sa1] : 16'bz;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem0[pl_addr] <= pl_data;
        else if (!ce0_n && !we0_n) mem0[sa0] <= dq0;
    end

    always @(posedge clk) begin
        if (pl_en && pl_sel) mem1[pl_addr] <= pl_data;
        else if (!ce1_n && !we1_n) mem1[sa1] <= dq1;
    end

    typedef struct {
        logic [127:0] rd;
        int           cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    // monitors: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                fail_now("dut0 done with no outstanding request: got done=1 expected 0");
            end else begin
                e0 = q0.pop_front();
                chk("dut0 rdata", {64'd0, rd0}, e0.rd);
                chk("dut0 done cycle", 128'(cyc), 128'(e0.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                fail_now("dut1 done with no outstanding request: got done=1 expected 0");
            end else begin
                e1 = q1.pop_front();
                chk("dut1 rdata", rd1, e1.rd);
                chk("dut1 done cycle", 128'(cyc), 128'(e1.cyc));
            end
        end
    end

    task automatic preload(input logic sel, input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Present a request at a negedge; the cycle it is accepted in is cycle 0.
    task automatic issue(input int sel, input logic we, input logic [31:0] addr,
                         input logic [127:0] wd, input logic [127:0] exp_rd, input bit exp_done);
        int n;
        exp_t e;
        @(negedge clk);
        if (sel == 0) begin v0 = 1'b1; we0i = we; a0 = addr; wd0 = wd[63:0]; end
        else begin v1 = 1'b1; we1i = we; a1 = addr; wd1 = wd; end
        n = 0;
        while (((sel == 0) ? rdy0 : rdy1) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            fail_now("issue: req_ready got 0 expected 1 within 40 cycles");
        end else if (exp_done) begin
            e.rd  = exp_rd;
            e.cyc = cyc + 9;
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    // Per-cycle strobe/address check across the ACCESS cycles of a burst.
    task automatic check_burst(input int sel, input logic [17:0] base, input logic we,
                               input int beats, input int waitc);
        logic [17:0] sa, ea;
        logic        wn, on, rdy;
        logic [2:0]  cul;
        int          b, w;
        for (int k = 0; k < beats * (waitc + 1); k++) begin
            @(negedge clk);
            b = k / (waitc + 1);
            w = k % (waitc + 1);
            if (sel == 0) begin sa = sa0; wn = we0_n; on = oe0_n; cul = {ce0_n, ub0_n, lb0_n}; rdy = rdy0; end
            else begin sa = sa1; wn = we1_n; on = oe1_n; cul = {ce1_n, ub1_n, lb1_n}; rdy = rdy1; end
            ea = base + 18'(b);
            chk("burst sram_addr", 128'(sa), 128'(ea));
            chk("burst sram_we_n", 128'(wn), (we && !(waitc > 0 && w == 0)) ? 128'd0 : 128'd1);
            chk("burst sram_oe_n", 128'(on), we ? 128'd1 : 128'd0);
            chk("burst ce/ub/lb", 128'(cul), 128'd0);
            chk("burst req_ready", 128'(rdy), 128'd0);
        end
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) fail_now("wait_idle: done pulse missing within 40 cycles");
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        int acc_c [2];
        rst = 1'b1;
        v0 = 1'b0; we0i = 1'b0; a0 = 32'd0; wd0 = 64'd0;
        v1 = 1'b0; we1i = 1'b0; a1 = 32'd0; wd1 = 128'd0;
        pl_en = 1'b0; pl_sel = 1'b0; pl_addr = 18'd0; pl_data = 16'd0;
        repeat (3) @(negedge clk);

        // reset values
        chk("reset req_ready", 128'(rdy0), 128'd1);
        chk("reset done", 128'(done0), 128'd0);
        chk("reset rdata", {64'd0, rd0}, 128'd0);
        chk("reset sram_addr", 128'(sa0), 128'd0);
        chk("reset strobes", 128'({ce0_n, oe0_n, we0_n, ub0_n, lb0_n}), 128'h1f);
        chk("reset dut1 rdata", rd1, 128'd0);
        rst = 1'b0;

        // read line
        preload(1'b0, 18'h100, 16'h1111);
        preload(1'b0, 18'h101, 16'h2222);
        preload(1'b0, 18'h102, 16'h3333);
        preload(1'b0, 18'h103, 16'h4444);
        issue(0, 1'b0, 32'h200, 128'd0, 128'h4444_3333_2222_1111, 1'b1);
        check_burst(0, 18'h100, 1'b0, 4, 1);
        wait_idle(0);

        // write, then read back
        issue(0, 1'b1, 32'h208, 128'hDEADBEEF_CAFEF00D, 128'h4444_3333_2222_1111, 1'b1);
        check_burst(0, 18'h104, 1'b1, 4, 1);
        wait_idle(0);
        chk("mem 0x104", 128'(mem0[18'h104]), 128'hF00D);
        chk("mem 0x105", 128'(mem0[18'h105]), 128'hCAFE);
        chk("mem 0x106", 128'(mem0[18'h106]), 128'hBEEF);
        chk("mem 0x107", 128'(mem0[18'h107]), 128'hDEAD);
        issue(0, 1'b0, 32'h208, 128'd0, 128'hDEADBEEF_CAFEF00D, 1'b1);
        check_burst(0, 18'h104, 1'b0, 4, 1);
        wait_idle(0);

        // alignment and wrap at the top of SRAM
        preload(1'b0, 18'h3FFFC, 16'h5A00);
        preload(1'b0, 18'h3FFFD, 16'h5A01);
        preload(1'b0, 18'h3FFFE, 16'h5A02);
        preload(1'b0, 18'h3FFFF, 16'h5A03);
        issue(0, 1'b0, 32'h7FFFE, 128'd0, 128'h5A03_5A02_5A01_5A00, 1'b1);
        check_burst(0, 18'h3FFFC, 1'b0, 4, 1);
        wait_idle(0);
        preload(1'b0, 18'h3FFF8, 16'h6B00);
        preload(1'b0, 18'h3FFF9, 16'h6B01);
        preload(1'b0, 18'h3FFFA, 16'h6B02);
        preload(1'b0, 18'h3FFFB, 16'h6B03);
        issue(0, 1'b0, 32'h1FFFF6, 128'd0, 128'h6B03_6B02_6B01_6B00, 1'b1);
        check_burst(0, 18'h3FFF8, 1'b0, 4, 1);
        wait_idle(0);

        // back-pressure: req_valid held for 20 cycles
        acc_n = 0;
        acc_c[0] = -1;
        acc_c[1] = -1;
        @(negedge clk);
        v0 = 1'b1; we0i = 1'b0; a0 = 32'h200;
        for (int i = 0; i < 20; i++) begin
            chk("backpressure req_ready", 128'(rdy0), (i == 0 || i == 10) ? 128'd1 : 128'd0);
            if (rdy0 === 1'b1) begin
                if (acc_n < 2) acc_c[acc_n] = i;
                acc_n++;
                q0.push_back('{rd: 128'h4444_3333_2222_1111, cyc: cyc + 9});
            end
            @(negedge clk);
        end
        v0 = 1'b0;
        wait_idle(0);
        chk("backpressure accept count", 128'(acc_n), 128'd2);
        chk("backpressure first accept", 128'(acc_c[0]), 128'd0);
        chk("backpressure second accept", 128'(acc_c[1]), 128'd10);

        // reset during beat 2 of a write
        issue(0, 1'b1, 32'h208, 128'h12345678_9ABCDEF0, 128'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk("midburst beat2 addr", 128'(sa0), 128'h106);
        chk("midburst beat2 setup we_n", 128'(we0_n), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midburst strobes after reset", 128'({ce0_n, oe0_n, we0_n, ub0_n, lb0_n}), 128'h1f);
        chk("midburst req_ready after reset", 128'(rdy0), 128'd1);
        chk("midburst done after reset", 128'(done0), 128'd0);
        chk("midburst rdata cleared", {64'd0, rd0}, 128'd0);
        repeat (12) @(negedge clk);
        chk("midburst mem 0x104", 128'(mem0[18'h104]), 128'hDEF0);
        chk("midburst mem 0x105", 128'(mem0[18'h105]), 128'h9ABC);
        chk("midburst mem 0x106", 128'(mem0[18'h106]), 128'hBEEF);
        chk("midburst mem 0x107", 128'(mem0[18'h107]), 128'hDEAD);

        // parameter sweep: 8 beats, no wait states
        for (int i = 0; i < 8; i++) preload(1'b1, 18'h40 + 18'(i), 16'h0A00 + 16'(i));
        issue(1, 1'b0, 32'h86, 128'd0, 128'h0A07_0A06_0A05_0A04_0A03_0A02_0A01_0A00, 1'b1);
        check_burst(1, 18'h40, 1'b0, 8, 0);
        wait_idle(1);
        issue(1, 1'b1, 32'h90, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
              128'h0A07_0A06_0A05_0A04_0A03_0A02_0A01_0A00, 1'b1);
        check_burst(1, 18'h48, 1'b1, 8, 0);
        wait_idle(1);
        chk("dut1 mem 0x48", 128'(mem1[18'h48]), 128'h3210);
        chk("dut1 mem 0x4F", 128'(mem1[18'h4F]), 128'h0123);
        issue(1, 1'b0, 32'h90, 128'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);
        check_burst(1, 18'h48, 1'b0, 8, 0);
        wait_idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Parametrised controller between the ARM core's cache/memory stage and the DE2 board's asynchronous 16-bit SRAM. It accepts one line-sized read or write request per handshake and splits it into consecutive half-word SRAM beats. Each beat is stretched by configurable wait states. A full line is reassembled for reads. It replaces the fixed single-word SRAM access path and sits directly under `arm_processor`, driving the `SRAM_*` pins.

## Interface
- `ADDR_W`, 18: SRAM half-word address width.
- `DQ_W`, 16: SRAM data bus width.
- `WORD_W`, 32: CPU word width. Must be a multiple of `DQ_W`.
- `BURST_LEN`, 2: words per request. Must be a power of two, ≥1.
- `WAIT_CYCLES`, 1: extra clock cycles per beat. Range 0–7.
- Derived `BEATS = BURST_LEN*WORD_W/DQ_W` and `LINE_W = BURST_LEN*WORD_W`.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = write line, 0 = read line.
- `req_addr` in 32: byte address.
- `wdata` in `LINE_W`: write line, little-endian by beat.
- `rdata` out `LINE_W`: read line.
- `done` out 1: one-cycle completion pulse. For reads, `rdata` is valid in the same cycle.
- `sram_dq` inout `DQ_W`: SRAM data bus.
- `sram_addr` out `ADDR_W`: SRAM half-word address.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n` out 1 each: active-low SRAM strobes.

## Operation
- FSM states: `IDLE`, `ACCESS`, `DONE`.
- `IDLE`
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch `req_we`, `wdata` and the base address, clear the beat and wait counters, and go to `ACCESS`.
- Base address
  - Line-aligned half-word address: `(req_addr >> 1)` with the low `log2(BEATS)` bits forced to 0, truncated to `ADDR_W`.
  - Beat `b` uses `sram_addr = base + b`, computed modulo 2^`ADDR_W`, so addresses wrap at the top of SRAM.
- `ACCESS`
  - Each beat lasts `WAIT_CYCLES+1` cycles.
  - Beat `b` carries `line[(b+1)*DQ_W-1 : b*DQ_W]`.
  - Read: `sram_dq` is Hi-Z. On the last cycle of a beat, `sram_dq` is captured into the beat's slice of the `rdata` holding register.
  - Write: `sram_dq` carries the latched beat slice for the whole beat.
  - After the last cycle of beat `BEATS-1`, go to `DONE`.
- `DONE`
  - `done` = 1 for exactly one cycle.
  - Next state is `IDLE`.
  - `rdata` holds its value until the next read completes; writes do not change `rdata`.
- Requests while busy: `req_ready` = 0 in `ACCESS` and `DONE`, and `req_valid` is ignored there. There is no queuing.
- Reset, including mid-burst: next state is `IDLE`, with no `done` pulse and no further SRAM write strobes. `rdata` is cleared to 0.

## Timing
- All outputs are registered except `sram_dq`. `sram_dq` is a tri-state driven by a registered enable and registered data.
- Values after reset:
  - `req_ready` = 1 and `done` = 0.
  - `rdata` = 0 and `sram_addr` = 0.
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` = 1.
  - `sram_dq` = Z.
- In `IDLE` and `DONE`, all strobes are 1 and `sram_dq` = Z.
- In `ACCESS`, `sram_ce_n` = `sram_ub_n` = `sram_lb_n` = 0.
- Read beat: `sram_oe_n` = 0 and `sram_we_n` = 1.
- Write beat: `sram_oe_n` = 1.
  - If `WAIT_CYCLES` ≥ 1, `sram_we_n` = 1 on the first cycle of each beat (address setup) and 0 on the remaining cycles.
  - If `WAIT_CYCLES` = 0, `sram_we_n` = 0 for the whole beat.
- Latency:
  - Handshake at edge 0; the first `ACCESS` cycle is cycle 1.
  - `done` is high in cycle `BEATS*(WAIT_CYCLES+1)+1`.
  - `req_ready` returns to 1 in the following cycle.
- Throughput: one request per `BEATS*(WAIT_CYCLES+1)+2` cycles.

## Test plan
All scenarios use default parameters unless stated, so `BEATS` = 4 and `done` falls in cycle 9.

- **Read line:** preload SRAM half-words 0x100..0x103 with 0x1111, 0x2222, 0x3333, 0x4444, then read `req_addr` = 0x200.
  - `sram_addr` steps 0x100→0x103, two cycles each.
  - `done` is high in cycle 9 with `rdata` = 0x4444_3333_2222_1111.
- **Write then read back:** write `wdata` = 0xDEADBEEF_CAFEF00D to `req_addr` = 0x208.
  - SRAM 0x104..0x107 holds F00D, CAFE, BEEF, DEAD.
  - `sram_we_n` is high in each beat's first cycle.
  - A read of the same address returns the same line.
- **Alignment and wrap:** read `req_addr` = 0x7FFFE (top of SRAM).
  - Base = 0x3FFFC, beats hit 0x3FFFC..0x3FFFF.
  - Read `req_addr` = 0x1FFFF6, a byte address beyond the 18-bit half-word range, and check that the truncated base wraps mod 2^18.
- **Back-pressure:** hold `req_valid` = 1 for 20 cycles.
  - `req_ready` = 0 in cycles 1–9.
  - Exactly two requests are accepted, at cycles 0 and 10.
- **Reset mid-burst:** assert `rst` for one cycle during beat 2 of a write.
  - The next cycle is `IDLE` with all strobes at 1 and no `done` pulse.
  - SRAM 0x106..0x107 is unchanged.
- **Parameter sweep:** set `WAIT_CYCLES` = 0 and `BURST_LEN` = 4 (`BEATS` = 8).
  - `done` is high in cycle 9.
  - An 8-beat read assembles a 128-bit `rdata` in little-endian beat order.
